// File: rtl/fighter_pkg.sv
// Shared fighter types: FSM states, action bit positions, facing codes, screen geometry.
// Pure declarations; no latency or flow control.
// No backpressure.
package fighter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WALK,
        ST_ATTACK,
        ST_SHIELD,
        ST_STUN,
        ST_KO
    } state_t;

    localparam int ACT_FACING = 6;
    localparam int ACT_STRIKE = 5;
    localparam int ACT_WIND   = 4;
    localparam int ACT_AIR    = 3;
    localparam int ACT_SHIELD = 2;
    localparam int ACT_WALK   = 1;
    localparam int ACT_STUN   = 0;

    localparam logic LEFT  = 1'b1;
    localparam logic RIGHT = 1'b0;

    localparam int SCREEN_X_MIN    = 144;
    localparam int SCREEN_X_MAX    = 656;
    localparam int GROUND_LINE     = 394;
    localparam int SPRITE_SIZE     = 128;
    localparam int SCREEN_GROUND_Y = GROUND_LINE - SPRITE_SIZE;

    localparam logic [3:0] ATK_LAST = 4'd11;

endpackage

// File: rtl/fighter_jump.sv
// Vertical integrator: y position, signed velocity and airborne flag, stepped once per tick.
// Latency: registered, updates on the clock edge that samples tick.
// No backpressure; freeze holds all state.
module fighter_jump
    import fighter_pkg::*;
#(
    parameter int GROUND_Y = SCREEN_GROUND_Y,
    parameter int JUMP_V0  = 14,
    parameter int GRAVITY  = 1
) (
    input  logic       clk,
    input  logic       rst_l,
    input  logic       tick,
    input  logic       freeze,
    input  logic       start,
    output logic [9:0] y,
    output logic       airborne,
    output logic       air_nxt
);

    localparam logic signed [11:0] GY = 12'(GROUND_Y);

    logic signed [5:0]  vy, vy_n, v_use;
    logic signed [11:0] y_calc;
    logic [9:0]         y_n;

    always_comb begin
        y_n     = y;
        vy_n    = vy;
        air_nxt = airborne;
        v_use   = vy;
        y_calc  = '0;
        if (tick && !freeze) begin
            // Launch and first integration step happen on the same tick.
            if (start) begin
                air_nxt = 1'b1;
                v_use   = 6'(JUMP_V0);
            end
            if (air_nxt) begin
                y_calc = $signed({2'b00, y}) - $signed({{6{v_use[5]}}, v_use});
                vy_n   = v_use - 6'(GRAVITY);
                if (y_calc >= GY) begin
                    y_n     = 10'(GROUND_Y);
                    vy_n    = '0;
                    air_nxt = 1'b0;
                end else begin
                    y_n = y_calc[9:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            y        <= 10'(GROUND_Y);
            vy       <= '0;
            airborne <= 1'b0;
        end else begin
            y        <= y_n;
            vy       <= vy_n;
            airborne <= air_nxt;
        end
    end

endmodule

// File: rtl/fighter_ctrl.sv
// Per-player game-state engine; optional shield regen under FIGHTER_SHIELD_REGEN_EN.
// Latency: outputs registered, change one cycle after frame_tick, held otherwise.
// No backpressure; game_over or KO freezes every register.
module fighter_ctrl
    import fighter_pkg::*;
#(
    parameter int PLAYER_NUM          = 1,
    parameter int START_X             = 200,
    parameter int GROUND_Y            = SCREEN_GROUND_Y,
    parameter int X_MIN               = SCREEN_X_MIN,
    parameter int X_MAX               = SCREEN_X_MAX,
    parameter int WALK_STEP           = 3,
    parameter int JUMP_V0             = 14,
    parameter int GRAVITY             = 1,
    parameter int STUN_FRAMES         = 8,
    parameter int SHIELD_REGEN_FRAMES = 60
) (
    input  logic       clk,
    input  logic       rst_l,
    input  logic       frame_tick,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_jump,
    input  logic       btn_attack,
    input  logic       btn_shield,
    input  logic [9:0] opp_x,
    input  logic       opp_hit,
    input  logic       game_over,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic [3:0] health,
    output logic [3:0] shield,
    output logic [6:0] action,
    output logic       attack_grant,
    output logic       ko
);

    if (STUN_FRAMES < 1 || STUN_FRAMES > 16 || SHIELD_REGEN_FRAMES < 1) begin : g_bad_cfg
        $error("fighter_ctrl: frame-count parameter out of range");
    end

    localparam logic              RESET_FACING = (PLAYER_NUM == 2) ? LEFT : RIGHT;
    localparam logic signed [10:0] XMIN_S      = 11'(X_MIN);
    localparam logic signed [10:0] XMAX_S      = 11'(X_MAX);

    state_t             state, st_n;
    logic [3:0]         cnt, cnt_n, health_n, shield_n;
    logic [9:0]         x_n;
    logic               facing, facing_n, hit_prev, atk_prev;
    logic [6:0]         action_n;
    logic               grant_n;
    logic               en, hit_edge, atk_edge, blocked, start, airborne, air_nxt, can_act;
    logic signed [10:0] step, x_calc;

`ifdef FIGHTER_SHIELD_REGEN_EN
    localparam int                 REGEN_W    = $clog2(SHIELD_REGEN_FRAMES + 1);
    localparam logic [REGEN_W-1:0] REGEN_LAST = REGEN_W'(SHIELD_REGEN_FRAMES - 1);
    logic [REGEN_W-1:0] regen, regen_n;
`endif

    assign en       = frame_tick && !game_over && (state != ST_KO);
    assign hit_edge = opp_hit && !hit_prev;
    assign atk_edge = btn_attack && !atk_prev;
    assign blocked  = hit_edge && (state == ST_SHIELD) && (shield != 4'd0);
    assign can_act  = (state == ST_IDLE || state == ST_WALK || state == ST_SHIELD)
                      && !(hit_edge && !blocked);

    always_comb begin
        st_n     = state;
        cnt_n    = cnt;
        health_n = health;
        shield_n = shield;
        facing_n = facing;
        start    = 1'b0;
        step     = '0;
        x_calc   = '0;
        x_n      = x;
`ifdef FIGHTER_SHIELD_REGEN_EN
        regen_n  = regen;
`endif
        if (en) begin
            if (blocked) begin
                shield_n = shield - 4'd1;
            end else if (hit_edge) begin
                health_n = (health == 4'd0) ? 4'd0 : health - 4'd1;
                st_n     = (health_n == 4'd0) ? ST_KO : ST_STUN;
                cnt_n    = 4'(STUN_FRAMES - 1);
            end else if (state == ST_STUN) begin
                if (cnt == 4'd0) st_n = ST_IDLE;
                else             cnt_n = cnt - 4'd1;
            end else if (state == ST_ATTACK) begin
                if (cnt == ATK_LAST) st_n = ST_IDLE;
                else                 cnt_n = cnt + 4'd1;
            end

            // A running attack or stun ignores buttons until it finishes.
            if (can_act) begin
                if (btn_shield && !airborne) begin
                    st_n = ST_SHIELD;
                end else if (atk_edge) begin
                    st_n  = ST_ATTACK;
                    cnt_n = '0;
                end else if (btn_left ^ btn_right) begin
                    st_n = ST_WALK;
                    step = btn_right ? 11'(WALK_STEP) : -11'(WALK_STEP);
                end else begin
                    st_n = ST_IDLE;
                end
                start = btn_jump && !airborne && (st_n == ST_IDLE || st_n == ST_WALK);
            end

            x_calc = $signed({1'b0, x}) + step;
            if (x_calc < XMIN_S)      x_n = 10'(X_MIN);
            else if (x_calc > XMAX_S) x_n = 10'(X_MAX);
            else                      x_n = x_calc[9:0];

            if (!air_nxt && st_n != ST_ATTACK) begin
                if (opp_x < x_n)      facing_n = LEFT;
                else if (opp_x > x_n) facing_n = RIGHT;
            end

`ifdef FIGHTER_SHIELD_REGEN_EN
            if (blocked) begin
                regen_n = '0;
            end else if (state != ST_SHIELD && state != ST_STUN) begin
                if (regen == REGEN_LAST) begin
                    regen_n = '0;
                    if (shield != 4'hF) shield_n = shield + 4'd1;
                end else begin
                    regen_n = regen + 1'b1;
                end
            end
`endif
        end

        grant_n              = (st_n == ST_ATTACK) && (cnt_n[3:2] == 2'b01);
        action_n             = '0;
        action_n[ACT_FACING] = facing_n;
        action_n[ACT_STRIKE] = grant_n;
        action_n[ACT_WIND]   = (st_n == ST_ATTACK) && !grant_n;
        action_n[ACT_AIR]    = air_nxt;
        action_n[ACT_SHIELD] = (st_n == ST_SHIELD);
        action_n[ACT_WALK]   = (st_n == ST_WALK);
        action_n[ACT_STUN]   = (st_n == ST_STUN);
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            x            <= 10'(START_X);
            health       <= 4'hF;
            shield       <= 4'hF;
            facing       <= RESET_FACING;
            hit_prev     <= 1'b0;
            atk_prev     <= 1'b0;
            action       <= {RESET_FACING, 6'b0};
            attack_grant <= 1'b0;
            ko           <= 1'b0;
        end else if (en) begin
            state        <= st_n;
            cnt          <= cnt_n;
            x            <= x_n;
            health       <= health_n;
            shield       <= shield_n;
            facing       <= facing_n;
            hit_prev     <= opp_hit;
            atk_prev     <= btn_attack;
            action       <= action_n;
            attack_grant <= grant_n;
            ko           <= (st_n == ST_KO);
        end
    end

`ifdef FIGHTER_SHIELD_REGEN_EN
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) regen <= '0;
        else if (en) regen <= regen_n;
    end
`endif

    fighter_jump #(
        .GROUND_Y (GROUND_Y),
        .JUMP_V0  (JUMP_V0),
        .GRAVITY  (GRAVITY)
    ) u_jump (
        .clk      (clk),
        .rst_l    (rst_l),
        .tick     (en),
        .freeze   (st_n == ST_KO),
        .start    (start),
        .y        (y),
        .airborne (airborne),
        .air_nxt  (air_nxt)
    );

endmodule

// File: tb/tb_fighter_ctrl.sv
// Scoreboard bench for fighter_ctrl (P2, START_X=600): expectations queued per tick, monitor compares.
module tb_fighter_ctrl;

    logic       clk = 1'b0, rst_l = 1'b0, frame_tick = 1'b0, probe = 1'b0;
    logic       btn_left = 1'b0, btn_right = 1'b0, btn_jump = 1'b0, btn_attack = 1'b0, btn_shield = 1'b0;
    logic [9:0] opp_x = 10'd100;
    logic       opp_hit = 1'b0, game_over = 1'b0;
    logic [9:0] x, y;
    logic [3:0] health, shield;
    logic [6:0] action;
    logic       attack_grant, ko;

    typedef struct {
        logic [5:0] chk;   // 0 x, 1 y, 2 health, 3 shield, 4 grant, 5 ko
        logic [9:0] x;
        logic [9:0] y;
        logic [3:0] h;
        logic [3:0] s;
        logic [6:0] am;
        logic [6:0] a;
        logic       g;
        logic       k;
    } exp_t;

    localparam logic [5:0] ALL = 6'h3F;

    exp_t  exp_q[$];
    string nm_q[$];
    int    n_run = 0, n_fail = 0;

    always #5 clk = ~clk;

    fighter_ctrl #(.PLAYER_NUM(2), .START_X(600)) dut (
        .clk(clk), .rst_l(rst_l), .frame_tick(frame_tick),
        .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump),
        .btn_attack(btn_attack), .btn_shield(btn_shield),
        .opp_x(opp_x), .opp_hit(opp_hit), .game_over(game_over),
        .x(x), .y(y), .health(health), .shield(shield), .action(action),
        .attack_grant(attack_grant), .ko(ko)
    );

    function automatic exp_t mk(input logic [5:0] chk, input logic [9:0] ex, input logic [9:0] ey,
                                input logic [3:0] eh, input logic [3:0] es, input logic [6:0] am,
                                input logic [6:0] ea, input logic eg, input logic ek);
        exp_t e;
        e.chk = chk; e.x = ex; e.y = ey; e.h = eh; e.s = es;
        e.am = am; e.a = ea; e.g = eg; e.k = ek;
        return e;
    endfunction

    task automatic cmp(input string nm, input string f, input logic [9:0] got, input logic [9:0] want);
        n_run++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s.%s got=%0d want=%0d", nm, f, got, want);
        end
    endtask

    task automatic tick(input string nm, input exp_t e);
        exp_q.push_back(e);
        nm_q.push_back(nm);
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        @(negedge clk);
    endtask

    task automatic probe_now(input string nm, input exp_t e);
        exp_q.push_back(e);
        nm_q.push_back(nm);
        @(negedge clk); probe = 1'b1;
        @(negedge clk); probe = 1'b0;
        @(negedge clk);
    endtask

    function automatic logic [9:0] jump_y(input int t);
        int u;
        u = (t <= 14) ? t : 29 - t;
        return 10'(266 - (14 * u - (u * (u - 1)) / 2));
    endfunction

    exp_t  me;
    string mn;
    initial begin : monitor
        forever begin
            @(posedge clk);
            if (frame_tick || probe) begin
                @(negedge clk);
                if (exp_q.size() == 0) begin
                    n_run++;
                    n_fail++;
                    $display("FAIL unexpected_output got=none want=queued entry");
                end else begin
                    me = exp_q.pop_front();
                    mn = nm_q.pop_front();
                    if (me.chk[0]) cmp(mn, "x", x, me.x);
                    if (me.chk[1]) cmp(mn, "y", y, me.y);
                    if (me.chk[2]) cmp(mn, "health", 10'(health), 10'(me.h));
                    if (me.chk[3]) cmp(mn, "shield", 10'(shield), 10'(me.s));
                    if (me.chk[4]) cmp(mn, "attack_grant", 10'(attack_grant), 10'(me.g));
                    if (me.chk[5]) cmp(mn, "ko", 10'(ko), 10'(me.k));
                    if (me.am != 7'd0) cmp(mn, "action", 10'(action & me.am), 10'(me.a & me.am));
                end
            end
        end
    end

    initial begin : stim
        int xm;
        logic [6:0] ea;
        repeat (3) @(negedge clk);
        rst_l = 1'b1;
        probe_now("reset", mk(ALL, 600, 266, 15, 15, 7'h7F, 7'h40, 0, 0));
        for (int i = 0; i < 10; i++)
            tick("idle", mk(ALL, 600, 266, 15, 15, 7'h7F, 7'h40, 0, 0));

        btn_right = 1'b1;
        xm = 600;
        for (int i = 1; i <= 200; i++) begin
            xm = (xm + 3 > 656) ? 656 : xm + 3;
            tick("walk_right", mk(ALL, 10'(xm), 266, 15, 15, 7'h7F, 7'h42, 0, 0));
        end
        btn_left = 1'b1;
        tick("both_dirs", mk(ALL, 656, 266, 15, 15, 7'h7F, 7'h40, 0, 0));
        tick("both_dirs2", mk(ALL, 656, 266, 15, 15, 7'h7F, 7'h40, 0, 0));
        btn_left = 1'b0; btn_right = 1'b0;

        for (int t = 1; t <= 30; t++) begin
            btn_jump = (t == 1);
            tick("jump", mk(ALL, 656, jump_y(t > 29 ? 29 : t), 15, 15, 7'h7F,
                            (t < 29) ? 7'h48 : 7'h40, 0, 0));
        end
        btn_jump = 1'b0;

        btn_attack = 1'b1;
        for (int t = 1; t <= 20; t++) begin
            ea = (t <= 4 || (t >= 9 && t <= 12)) ? 7'h50 : (t <= 8) ? 7'h60 : 7'h40;
            tick("attack", mk(ALL, 656, 266, 15, 15, 7'h7F, ea, (t >= 5 && t <= 8), 0));
        end
        btn_attack = 1'b0;
        tick("attack_rel", mk(ALL, 656, 266, 15, 15, 7'h7F, 7'h40, 0, 0));

        btn_shield = 1'b1;
        tick("shield_on", mk(ALL, 656, 266, 15, 15, 7'h7F, 7'h44, 0, 0));
        for (int i = 1; i <= 14; i++) begin
            opp_hit = 1'b1;
            tick("blocked", mk(ALL, 656, 266, 15, 4'(15 - i), 7'h7F, 7'h44, 0, 0));
            opp_hit = 1'b0;
            tick("blocked_rel", mk(ALL, 656, 266, 15, 4'(15 - i), 7'h7F, 7'h44, 0, 0));
        end
        opp_hit = 1'b1;
        for (int t = 1; t <= 3; t++)
            tick("last_shield", mk(ALL, 656, 266, 15, 0, 7'h7F, 7'h44, 0, 0));
        opp_hit = 1'b0;
        tick("last_shield_rel", mk(ALL, 656, 266, 15, 0, 7'h7F, 7'h44, 0, 0));
        opp_hit = 1'b1;
        for (int t = 1; t <= 9; t++) begin
            if (t == 4) opp_hit = 1'b0;
            tick("shield_broken", mk(6'h0F, 656, 266, 14, 0, 7'h01, (t <= 8) ? 7'h01 : 7'h00, 0, 0));
        end
        btn_shield = 1'b0;

        for (int i = 1; i <= 13; i++) begin
            opp_hit = 1'b1;
            tick("hit", mk(6'h0C, 656, 266, 4'(14 - i), 0, 7'h01, 7'h01, 0, 0));
            opp_hit = 1'b0;
            tick("hit_rel", mk(6'h04, 656, 266, 4'(14 - i), 0, 7'h00, 7'h00, 0, 0));
        end
        for (int i = 0; i < 10; i++)
            tick("recover", mk(6'h04, 656, 266, 1, 0, 7'h00, 7'h00, 0, 0));
        tick("recovered", mk(ALL, 656, 266, 1, 0, 7'h7F, 7'h40, 0, 0));

        game_over = 1'b1; btn_left = 1'b1;
        tick("game_over_hold", mk(ALL, 656, 266, 1, 0, 7'h7F, 7'h40, 0, 0));
        game_over = 1'b0;
        tick("walk_left", mk(ALL, 653, 266, 1, 0, 7'h7F, 7'h42, 0, 0));
        btn_left = 1'b0;

        opp_hit = 1'b1; btn_jump = 1'b1;
        tick("ko", mk(ALL, 653, 266, 0, 0, 7'h7F, 7'h40, 0, 1));
        opp_hit = 1'b0; btn_jump = 1'b0; btn_right = 1'b1; btn_attack = 1'b1; opp_x = 10'd900;
        for (int i = 0; i < 5; i++)
            tick("ko_frozen", mk(ALL, 653, 266, 0, 0, 7'h7F, 7'h40, 0, 1));

        rst_l = 1'b0;
        btn_right = 1'b0; btn_attack = 1'b0; opp_x = 10'd100;
        repeat (2) @(negedge clk);
        rst_l = 1'b1;
        probe_now("reset_from_ko", mk(ALL, 600, 266, 15, 15, 7'h7F, 7'h40, 0, 0));

        repeat (4) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_run++;
            n_fail++;
            $display("FAIL drain got=%0d pending want=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/fighter_ctrl.md
# fighter_ctrl

- Per-player game-state engine, instantiated once per fighter.
- Sits directly upstream of the pixel-colour stage. Drives that stage's `pN_x`, `pN_y`, `pN_health`, `pN_shield`, `pN_action` and `pN_attack_grant` inputs.
- Advances movement, jump physics, attack timing, shield/damage bookkeeping and KO detection once per video frame on `frame_tick`.
- All outputs are registered and held stable for the whole visible frame.

## Interface
Parameters:
- `PLAYER_NUM`, 1 — 1 or 2; selects reset facing (P1 right, P2 left).
- `START_X`, 200 — reset x (top-left of 128×128 sprite, screen pixels).
- `GROUND_Y`, 266 — resting y (sprite bottom on ground line 394).
- `X_MIN`, 144 / `X_MAX`, 656 — horizontal clamp limits (inclusive).
- `WALK_STEP`, 3 — px per frame while walking.
- `JUMP_V0`, 14 — initial upward velocity, px/frame.
- `GRAVITY`, 1 — velocity decrement per frame.
- `STUN_FRAMES`, 8 — hit-stun length.
- `SHIELD_REGEN_FRAMES`, 60 — regen period.

Ports:
- `clk` in 1 — system clock.
- `rst_l` in 1 — asynchronous, active-low reset.
- `frame_tick` in 1 — one-cycle pulse per frame, issued during vblank.
- `btn_left`, `btn_right`, `btn_jump`, `btn_attack`, `btn_shield` in 1 each — debounced player inputs.
- `opp_x` in 10 — opponent x.
- `opp_hit` in 1 — opponent strike connecting this frame; the parent computes grant && collision && facing.
- `game_over` in 1 — freeze all state.
- `x`, `y` out 10 — sprite top-left.
- `health`, `shield` out 4 — 0..15.
- `action` out 7 — bit 6 facing (1=LEFT), 5 attack-active, 4 attack windup/recovery, 3 airborne, 2 shielding, 1 walking, 0 hit-stun.
- `attack_grant` out 1 — strike active window.
- `ko` out 1 — health reached 0 (sticky).

## Operation
- FSM states: IDLE, WALK, ATTACK, SHIELD, STUN, KO.
- Airborne is an orthogonal flag; vertical physics run in every non-KO state.
- Nothing changes except on `frame_tick`. When `game_over` or KO is active, every register holds.
- Per-tick evaluation order:
  1. Damage: on a rising edge of `opp_hit` sampled per tick, only one damage event per opponent strike.
     - If SHIELD and shield>0: shield−1, health unchanged, no stun.
     - Otherwise: health−1, saturating at 0, and enter STUN for `STUN_FRAMES`. This cancels ATTACK.
     - health==0 → KO, `ko`=1.
  2. Inputs, only when not in STUN:
     - `btn_shield` while grounded → SHIELD. Shield beats attack when both are pressed.
     - New `btn_attack` press (rising edge, sampled per tick) → ATTACK, 12 frames: 0–3 windup, 4–7 active, 8–11 recovery, then IDLE. The attack cannot be re-triggered until the button is released.
     - Exactly one of left/right → WALK ±`WALK_STEP`. Both or neither → no motion. Horizontal motion is permitted airborne; it is forbidden in ATTACK/SHIELD/STUN.
     - `btn_jump` while grounded and not in ATTACK/SHIELD → airborne, vy=`JUMP_V0`.
  3. Physics, when airborne:
     - y ← y−vy, then vy ← vy−`GRAVITY`. vy is 6-bit signed.
     - If the next y ≥ `GROUND_Y`: clamp y=`GROUND_Y`, vy=0, clear airborne.
  4. Clamp x to [`X_MIN`, `X_MAX`]. Compute in 11 bits so subtraction below 0 cannot wrap.
  5. Facing ← (opp_x < x) ? LEFT : RIGHT. Updated only when grounded and not in ATTACK. Ties keep the previous facing.
- `attack_grant` = 1 exactly during ATTACK frames 4–7.

## Timing
- Reset values:
  - x=`START_X`, y=`GROUND_Y`, health=15, shield=15.
  - action=7'b1000000 for P2, 0 for P1.
  - attack_grant=0, ko=0, FSM=IDLE, vy=0.
- All outputs update in the cycle after `frame_tick` (1-cycle latency) and are constant between ticks.
- Reset mid-jump or mid-attack returns immediately to reset values.
- A `frame_tick` coincident with `game_over` rising is ignored.

## Configuration
- `FIGHTER_SHIELD_REGEN_EN` defined: shield +1 every `SHIELD_REGEN_FRAMES` ticks while not in SHIELD/STUN. It saturates at 15, and the regen counter resets on any blocked hit.
- Undefined: shield only decreases; no regen counter is synthesized.

## Structure
- Shared package `fighter_pkg`:
  - state enum;
  - `action` bit indices;
  - LEFT=1/RIGHT=0;
  - screen constants (`X_MIN`, `X_MAX`, `GROUND_Y`, sprite size 128).
- One sub-module, `fighter_jump`: vertical integrator (y, vy, airborne) with inputs start/tick/freeze.

## Test plan
- Reset P2, then 10 ticks idle → x=START_X, y=266, health=15, shield=15, action=7'h40, attack_grant=0.
- Hold `btn_right` 200 ticks from x=600 → x saturates at 656, action[1]=1. Press both buttons → x unchanged, action[1]=0.
- Jump with JUMP_V0=14 → minimum y=266−105=161 at tick 14. Back to y=266, airborne clear, by tick 29.
- Tap attack, then hold it 20 ticks → attack_grant high on ticks 5–8 only, IDLE after tick 12, no second attack while held.
- `opp_hit` held high 3 ticks while in SHIELD with shield=1 → shield=0, health=15. Repeat → health=14, action[0]=1 for 8 ticks.
- health=1, hit arrives on the same tick as jump press → health=0, ko=1, jump ignored, all outputs frozen thereafter. With macro: shield regen +1 per 60 ticks only when not shielding.
